conv_accumulator: RTL
=====================

CONV_ACCUMULATOR -- requirements
Module: conv_accumulator

Interface
REQ-001 SHALL have parameter DW, default 8: width of signed two's-complement input terms.
REQ-002 SHALL have parameter KSIZE, default 9: terms per output window (3x3 kernel).
REQ-003 SHALL have parameter ACC_W, default 16: internal accumulator width; legal only if ACC_W >= DW+clog2(KSIZE)+1.
REQ-004 SHALL have parameter OUT_W, default 8: result width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port clr  input  1  synchronous window abort.
REQ-008 SHALL have port in_valid  input  1  input term present.
REQ-009 SHALL have port in_ready  output  1  block accepts a term this cycle.
REQ-010 SHALL have port in_data  input  DW  signed term (adder/subtractor sum).
REQ-011 SHALL have port in_sub  input  1  1 = subtract term, 0 = add.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port out_data  output  OUT_W  window result.
REQ-015 SHALL have port out_ovf  output  1  full sum outside signed OUT_W range.

Function
REQ-016 SHALL implement FSM states ACCUM and DONE.
- ACCUM: in_ready = !clr; out_valid = 0.
- DONE: in_ready = 0; out_valid = 1.
REQ-017 SHALL accept a term on in_valid & in_ready and update acc <= acc +/- sign-extended in_data (per in_sub) in that clock edge.
REQ-018 SHALL count accepted terms 0..KSIZE-1; on accepting term KSIZE-1 it SHALL clear cnt, move to DONE, and register out_data/out_ovf from the final sum.
REQ-019 SHALL present the result exactly one cycle after the last term is accepted (latency 1).
REQ-020 SHALL hold out_valid, out_data and out_ovf stable while out_ready = 0.
REQ-021 On out_valid & out_ready, SHALL clear acc to 0 and return to ACCUM; the next term is acceptable on the following cycle.
REQ-022 in_valid without in_ready SHALL leave acc and cnt unchanged.
REQ-023 clr SHALL take priority over any input beat: acc <= 0, cnt <= 0, state <= ACCUM, out_valid <= 0.
- Any beat in the clr cycle is not accepted.
- Any pending DONE result is discarded.
REQ-024 SHALL never overflow acc within one window, given the ACC_W rule in REQ-003.

Reset
REQ-025 rst SHALL asynchronously force state = ACCUM, acc = 0, cnt = 0, out_valid = 0, out_data = 0, out_ovf = 0, regardless of clk.
REQ-026 Reset asserted mid-window SHALL discard all partial terms; after release, the first accepted beat SHALL be term 0.

Configuration
REQ-027 With ACC_SATURATE_EN defined, out_data SHALL clamp the final sum to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-028 Without ACC_SATURATE_EN, out_data SHALL be the low OUT_W bits of the sum (wrap).
REQ-029 out_ovf SHALL behave identically in both builds.

Structure
REQ-030 Package conv_acc_pkg SHALL hold:
- the FSM state encoding;
- default DW/KSIZE/ACC_W/OUT_W constants;
- the saturation-limit function.
REQ-031 The add/subtract step SHALL be a combinational sub-module acc_addsub (ACC_W-bit, sub-select input) instantiated once.

Verification (KSIZE=9, DW=OUT_W=8, ACC_W=16)
REQ-032 Nine beats of +10, in_sub=0, out_ready=1 -> out_data=90, out_ovf=0, out_valid high exactly 1 cycle after the 9th accept.
REQ-033 Nine beats of 100, add -> sum 900, out_ovf=1.
- With macro: out_data=127 (0x7F).
- Without macro: out_data=0x84.
REQ-034 Nine beats of 20, in_sub=1 -> sum -180, out_ovf=1.
- With macro: out_data=0x80.
- Without macro: out_data=0x4C.
REQ-035 Backpressure: out_ready=0 for 5 cycles after DONE, in_valid=1 throughout -> out_valid/out_data stable, in_ready=0, no term accepted; release -> next window starts next cycle.
REQ-036 clr after 4 beats of 50, then nine beats of 1 -> out_data=9; separately, clr asserted in DONE -> result dropped, out_valid=0 next cycle.
REQ-037 rst pulsed between clock edges after 5 beats -> all outputs 0 immediately; nine beats of 2 afterwards -> out_data=18.

Source files
------------

// File: rtl/conv_acc_pkg.sv
// Shared definitions for the convolution window accumulator:
// FSM state encoding, default sizing constants and the output
// saturation limits.
package conv_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int DEF_DW    = 8;
    localparam int DEF_KSIZE = 9;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_OUT_W = 8;

    // Largest value representable in a signed w-bit result.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed w-bit result.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/acc_addsub.sv
// Combinational add/subtract step used by the window accumulator.
// y = a + b when sub = 0, y = a - b when sub = 1 (modulo 2^W).
module acc_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    // Select between sum and difference of the two operands.
    always_comb begin
        y = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/conv_accumulator.sv
// Convolution window accumulator: sums KSIZE signed terms (each added
// or subtracted) into an ACC_W-bit accumulator and emits one OUT_W-bit
// result per window, with an out-of-range flag.
//
// Optional feature: define ACC_SATURATE_EN to clamp out_data to the
// signed OUT_W range; otherwise out_data is the low OUT_W bits (wrap).
// out_ovf is the same in both builds.
//
// Handshake: a beat moves on a port in the cycle where its valid and
// ready are both high at the rising edge; valid never depends on ready,
// and the producer holds its data until that edge.
//
// ACC_W must be at least DW + clog2(KSIZE) + 1 so a full window can
// never overflow the accumulator.
module conv_accumulator
    import conv_acc_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int KSIZE = DEF_KSIZE,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_ovf,
    output state_t               dbg_state
);

    localparam int CNT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KSIZE - 1);
    localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'(sat_max(OUT_W));
    localparam logic signed [ACC_W-1:0] SUM_MIN = ACC_W'(sat_min(OUT_W));

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [ACC_W-1:0]   term_ext;
    logic [ACC_W-1:0]   acc_next;
    logic               accept;
    logic               too_big;
    logic               too_small;
    logic [OUT_W-1:0]   res_next;

    assign term_ext  = {{(ACC_W - DW){in_data[DW-1]}}, in_data};
    assign in_ready  = (state == ACCUM) && !clr;
    assign out_valid = (state == DONE);
    assign dbg_state = state;
    assign accept    = in_valid && in_ready;

    acc_addsub #(
        .W   (ACC_W)
    ) u_addsub (
        .a   (acc),
        .b   (term_ext),
        .sub (in_sub),
        .y   (acc_next)
    );

    // Range check and result formatting of the running sum including the current term.
    always_comb begin
        too_big   = $signed(acc_next) > SUM_MAX;
        too_small = $signed(acc_next) < SUM_MIN;
`ifdef ACC_SATURATE_EN
        if (too_big) begin
            res_next = SUM_MAX[OUT_W-1:0];
        end else if (too_small) begin
            res_next = SUM_MIN[OUT_W-1:0];
        end else begin
            res_next = acc_next[OUT_W-1:0];
        end
`else
        res_next = acc_next[OUT_W-1:0];
`endif
    end

    // Window FSM: accumulate terms, hold the result until consumed, abort on clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (clr) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        if (cnt == LAST_CNT) begin
                            cnt      <= '0;
                            state    <= DONE;
                            out_data <= res_next;
                            out_ovf  <= too_big || too_small;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule
